// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// bit-counter width rule.
package serial_adder_pkg;

  localparam logic [1:0] SA_IDLE = 2'd0;
  localparam logic [1:0] SA_RUN  = 2'd1;
  localparam logic [1:0] SA_DONE = 2'd2;

  // Counter must reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used as the bit-slice of serial_adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (A & C_in) | (B & C_in);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry register, LSB first.
// Optional subtract mode (SUB port, B inversion) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic [1:0]       state_dbg_o
);

  // Handshake: start is taken only while busy is low (IDLE); the accepting
  // edge captures A/B/C_in. done pulses one cycle with S/C_out valid, and
  // S/C_out then hold until the next result or reset.

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  logic             fa_b;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_word;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;
  assign fa_b = b_q[0] ^ sub_q;
`else
  assign fa_b = b_q[0];
`endif

  full_adder u_fa (
    .A     (a_q[0]),
    .B     (fa_b),
    .C_in  (carry_q),
    .S     (fa_s),
    .C_out (fa_co)
  );

  // Sum register holds the WIDTH-1 bits already produced; the current bit
  // completes the word on the final RUN edge.
  assign sum_word = {fa_s, sum_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      SA_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d   = SUB;
          carry_d = SUB ? 1'b1 : C_in;
`else
          carry_d = C_in;
`endif
          state_d = SA_RUN;
        end
      end
      SA_RUN: begin
        sum_d   = sum_word[WIDTH-1:1];
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          s_d     = sum_word;
          cout_d  = fa_co;
          state_d = SA_DONE;
        end
      end
      SA_DONE: state_d = SA_IDLE;
      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SA_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy        = (state_q != SA_IDLE);
  assign done        = (state_q == SA_DONE);
  assign S           = s_q;
  assign C_out       = cout_q;
  assign state_dbg_o = state_q;

endmodule : serial_adder
